add_seq_ctrl: RTL

//  Sequencer that performs one NBYTES*8-bit add or subtract on the shared 8-bit adder (A,B,CIN -> DOUT,COUT).
//  - Works byte-serially, LSB first, and chains the carry through a register.
//  - Sits between the operand/ALU control logic and the single 8-bit adder instance.
//  - Issues the operand bytes, collects the result bytes, and reports completion with a START/DONE handshake.

---
 rtl/add_seq_ctrl_pkg.sv | 24 ++
 rtl/add_seq_bytesel.sv | 34 +++
 rtl/add_seq_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/add_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// add_seq_ctrl_pkg
//   Shared definitions for the byte-serial add/subtract sequencer.
//   - BYTE_W  : width of one adder slice (the shared adder is 8 bits wide)
//   - state_t : sequencer states, ST_IDLE=0, ST_RUN=1, ST_DONE=2
//   - idx_w() : index width for a given number of operand bytes
// -----------------------------------------------------------------------------
package add_seq_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for NBYTES operand bytes. NBYTES is at least 2, so the
  // result is never zero.
  function automatic int idx_w(input int nbytes);
    return $clog2(nbytes);
  endfunction

endpackage

// File: rtl/add_seq_bytesel.sv
// -----------------------------------------------------------------------------
// add_seq_bytesel
//   Combinational NBYTES:1 byte selector. It picks byte[sel] out of a
//   packed NBYTES*BYTE_W operand, with byte 0 in the least significant
//   position. If sel is out of range, the output is zero.
//
// Ports
//   data     in   NBYTES*BYTE_W  packed operand
//   sel      in   IDX_W          byte index
//   byte_out out  BYTE_W         selected byte
// -----------------------------------------------------------------------------
module add_seq_bytesel
  import add_seq_ctrl_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int IDX_W  = idx_w(NBYTES)
) (
  input  logic [NBYTES*BYTE_W-1:0] data,
  input  logic [IDX_W-1:0]         sel,
  output logic [BYTE_W-1:0]        byte_out
);

  // NOTE: assigning a default before any conditional assignment keeps this
  // block purely combinational; without it, a missed sel value would infer a latch.
  always_comb begin
    byte_out = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (sel == IDX_W'(i)) begin
        byte_out = data[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// add_seq_ctrl
//   Byte-serial sequencer for one NBYTES*8-bit add or subtract on a shared,
//   purely combinational 8-bit adder that lives in the parent.
//
//   On an accepted start, the sequencer latches the operands. It then
//   presents one operand byte pair per cycle, LSB first, and captures the
//   adder's sum byte in the same cycle. The carry is chained through a
//   register. Subtraction uses A + ~B + 1: the B bytes are inverted and the
//   initial carry is forced to 1.
//
//   done pulses for one cycle when result/cout are valid. result and cout
//   hold until the next accepted start. A start in the done cycle is
//   accepted, so consecutive operations run without an idle gap.
//
// Optional feature
//   ADD_SEQ_OVF_EN : adds the ovf output (signed two's-complement overflow).
//
// Ports
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset
//   start     in   1   request; sampled only in IDLE or DONE
//   sub       in   1   0: opa+opb+cin, 1: opa-opb
//   cin       in   1   carry in (add only)
//   opa/opb   in   W   operands, W = NBYTES*8
//   busy      out  1   high while the operation is in flight
//   done      out  1   one-cycle completion pulse
//   result    out  W   sum / difference
//   cout      out  1   final carry (subtract: 1 = no borrow)
//   add_a     out  8   adder operand A byte (0 outside RUN)
//   add_b     out  8   adder operand B byte, inverted on subtract (0 outside RUN)
//   add_cin   out  1   adder carry in (0 outside RUN)
//   add_dout  in   8   adder sum byte
//   add_cout  in   1   adder carry out
//   ovf       out  1   signed overflow (only with ADD_SEQ_OVF_EN)
// -----------------------------------------------------------------------------
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int W      = NBYTES * BYTE_W,
  localparam int IDX_W  = idx_w(NBYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sub,
  input  logic              cin,
  input  logic [W-1:0]      opa,
  input  logic [W-1:0]      opb,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      result,
  output logic              cout,
  output logic [BYTE_W-1:0] add_a,
  output logic [BYTE_W-1:0] add_b,
  output logic              add_cin,
  input  logic [BYTE_W-1:0] add_dout,
  input  logic              add_cout
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  state_t            state_q;
  state_t            state_d;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic              sub_q;
  logic              carry_q;
  logic [IDX_W-1:0]  idx_q;

  logic              accept;
  logic              in_run;
  logic              last_byte;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;

  // A start is honoured only when no operation is in flight. A start in the
  // DONE cycle begins the next operation immediately.
  assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign in_run    = (state_q == ST_RUN);
  assign last_byte = (idx_q == IDX_LAST);

  // ---------------------------------------------------------------------------
  // Operand byte selection (the write-back into result stays here)
  // ---------------------------------------------------------------------------
  add_seq_bytesel #(.NBYTES(NBYTES)) u_sel_a (
    .data     (a_q),
    .sel      (idx_q),
    .byte_out (a_byte)
  );

  add_seq_bytesel #(.NBYTES(NBYTES)) u_sel_b (
    .data     (b_q),
    .sel      (idx_q),
    .byte_out (b_byte)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs as they were before the edge, in any evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)     state_d = ST_RUN;
      ST_RUN:  if (last_byte) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The adder inputs derive only from registered state, and
  // they are forced to zero outside RUN so the shared adder sees quiet inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy    = in_run;
    done    = (state_q == ST_DONE);
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (in_run) begin
      add_a   = a_byte;
      add_b   = b_byte ^ {BYTE_W{sub_q}};
      add_cin = carry_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand latches, carry chain, byte index and result write-back.
  // The operands are latched at accept, so later input changes cannot
  // disturb the operation in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      result  <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_q     <= opa;
      b_q     <= opb;
      sub_q   <= sub;
      // Subtract is A + ~B + 1, so the chain starts with carry 1.
      carry_q <= sub | cin;
      idx_q   <= '0;
      result  <= '0;
      cout    <= 1'b0;
    end else if (in_run) begin
      result[idx_q*BYTE_W +: BYTE_W] <= add_dout;
      carry_q                        <= add_cout;
      if (last_byte) begin
        cout <= add_cout;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

`ifdef ADD_SEQ_OVF_EN
  // Signed overflow is the carry out of bit 7 XOR the carry into bit 7 of
  // the top byte. The carry into bit 7 is recovered from the sum bit as
  // dout[7]^a[7]^b[7], using the adder-facing (possibly inverted) B.
  logic carry_into_msb;
  assign carry_into_msb = add_dout[BYTE_W-1] ^ add_a[BYTE_W-1] ^ add_b[BYTE_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (accept) begin
      ovf <= 1'b0;
    end else if (in_run && last_byte) begin
      ovf <= add_cout ^ carry_into_msb;
    end
  end
`endif

endmodule
